w0rm_core_redirect_ctrl: RTL

W0RM_CORE_REDIRECT_CTRL -- requirements
Module: w0rm_core_redirect_ctrl

---
 rtl/w0rm_core_pkg.sv | 24 ++
 rtl/w0rm_core_flush_counter.sv | 49 ++++
 rtl/w0rm_core_redirect_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/w0rm_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : w0rm_core_pkg
// Description : Shared definitions for the w0rm core redirect controller:
//               FSM state encoding, flush counter width and the default
//               flush length.
// Revision    : 1.0 - initial release
// ============================================================================
package w0rm_core_pkg;

    // Redirect controller FSM state encoding
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] ISSUE = 2'd3;

    // Default number of cycles flush_pipeline is held (legal range 1..15)
    localparam int FLUSH_CYCLES_DEFAULT = 2;

    // Flush down-counter width, sized for the largest legal flush length
    localparam int FLUSH_CNT_W = 4;

endpackage : w0rm_core_pkg
`default_nettype wire

// File: rtl/w0rm_core_flush_counter.sv
`default_nettype none
// ============================================================================
// Module      : w0rm_core_flush_counter
// Description : Loadable down-counter timing the pipeline flush window.
//               Saturates at zero and flags when it has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module w0rm_core_flush_counter
    import w0rm_core_pkg::*;
#(
    parameter int WIDTH = FLUSH_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority over counting; counting stops at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared immediately on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Zero flag ends the flush window
    always_comb begin
        zero_o = (count_q == '0);
    end

endmodule : w0rm_core_flush_counter
`default_nettype wire

// File: rtl/w0rm_core_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : w0rm_core_redirect_ctrl
// Description : Front-end redirect controller. After reset it issues
//               RESET_VECTOR; afterwards it captures a branch target (or,
//               when enabled, an interrupt vector), flushes the pipeline for
//               FLUSH_CYCLES cycles and then presents the new fetch address
//               until the fetch stage accepts it.
//               Build option: define W0RM_REDIRECT_IRQ_EN to enable the
//               interrupt redirect path; otherwise irq_req/irq_vector are
//               ignored and irq_ack is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module w0rm_core_redirect_ctrl
    import w0rm_core_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    input  logic                  irq_req,
    input  logic [ADDR_WIDTH-1:0] irq_vector,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  fetch_pc_valid,
    output logic                  flush_pipeline,
    output logic                  stall,
    output logic                  irq_ack
);

    // Counter is loaded with FLUSH_CYCLES-1 so that FLUSH lasts exactly
    // FLUSH_CYCLES cycles (the zero cycle is the last flush cycle).
    localparam logic [FLUSH_CNT_W-1:0] c_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_d;
    logic                  irq_ack_q;
    logic                  irq_ack_d;

    logic                  w_branch_take;
    logic                  w_irq_take;
    logic                  w_cnt_zero;

    // Requests are only sampled in IDLE; a branch always beats an interrupt
    assign w_branch_take = (state_q == IDLE) && branch_req;

`ifdef W0RM_REDIRECT_IRQ_EN
    assign w_irq_take = (state_q == IDLE) && !branch_req && irq_req;
`else
    // Interrupt path compiled out; the ports stay on the interface
    logic w_unused_irq;
    assign w_unused_irq = irq_req ^ (^irq_vector);
    assign w_irq_take   = 1'b0;
`endif

    w0rm_core_flush_counter #(
        .WIDTH      (FLUSH_CNT_W)
    ) u_flush_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (w_branch_take || w_irq_take),
        .load_val_i (c_FLUSH_LOAD),
        .en_i       (state_q == FLUSH),
        .zero_o     (w_cnt_zero)
    );

    // FSM state register; reset discards any captured redirect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = ISSUE;
            IDLE:    if (w_branch_take || w_irq_take) state_d = FLUSH;
            FLUSH:   if (w_cnt_zero) state_d = ISSUE;
            ISSUE:   if (fetch_ready) state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    // Redirect target and interrupt acknowledge next values
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        irq_ack_d  = w_irq_take;
        if (state_q == BOOT) begin
            fetch_pc_d = RESET_VECTOR;
        end else if (w_branch_take) begin
            fetch_pc_d = branch_pc;
        end else if (w_irq_take) begin
            fetch_pc_d = irq_vector;
        end
    end

    // Redirect target and acknowledge registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_VECTOR;
            irq_ack_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            irq_ack_q  <= irq_ack_d;
        end
    end

    // FSM outputs decoded from state; valid and flush are mutually exclusive
    always_comb begin
        fetch_pc       = fetch_pc_q;
        fetch_pc_valid = (state_q == ISSUE);
        flush_pipeline = (state_q == FLUSH);
        stall          = (state_q != IDLE);
        irq_ack        = irq_ack_q;
    end

endmodule : w0rm_core_redirect_ctrl
`default_nettype wire
